// File: rtl/wvb_rd_addr_ctrl_mc_if.sv
// Bus bundle between a waveform-buffer reader client and wvb_rd_addr_ctrl_mc.
// master drives header/read strobes and per-channel address tables; slave returns the read address and status.
interface wvb_rd_addr_ctrl_mc_if #(
  parameter int P_ADR_WIDTH = 15,
  parameter int P_N_CH      = 4
);
  localparam int P_CH_WIDTH = (P_N_CH > 1) ? $clog2(P_N_CH) : 1;

  logic [P_N_CH*P_ADR_WIDTH-1:0] start_addr;
  logic [P_N_CH*P_ADR_WIDTH-1:0] stop_addr;
  logic [P_CH_WIDTH-1:0]         hdr_ch;
  logic                          hdr_rdreq;
  logic                          wvb_rdreq;
  logic                          wvb_rddone;
  logic [P_ADR_WIDTH-1:0]        wvb_rd_addr;
  logic [P_CH_WIDTH-1:0]         rd_ch;
  logic                          rd_busy;
  logic                          rd_last;
  logic                          rd_overrun;
  logic [P_ADR_WIDTH:0]          rd_word_cnt;

  modport master (
    output start_addr, stop_addr, hdr_ch, hdr_rdreq, wvb_rdreq, wvb_rddone,
    input  wvb_rd_addr, rd_ch, rd_busy, rd_last, rd_overrun, rd_word_cnt
  );

  modport slave (
    input  start_addr, stop_addr, hdr_ch, hdr_rdreq, wvb_rdreq, wvb_rddone,
    output wvb_rd_addr, rd_ch, rd_busy, rd_last, rd_overrun, rd_word_cnt
  );
endinterface

// File: rtl/wvb_rd_addr_ctrl_mc.sv
// Multi-channel waveform-buffer read address sequencer: header wait, word reads, end-of-waveform skip.
// Define WVB_RD_WORD_CNT_EN to enable the per-waveform word counter on rd_word_cnt.
module wvb_rd_addr_ctrl_mc #(
  parameter int P_ADR_WIDTH = 15,
  parameter int P_DEPTH     = 2**P_ADR_WIDTH,
  parameter int P_N_CH      = 4,
  parameter int P_HDR_WAIT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wvb_rd_addr_ctrl_mc_if.slave  bus
);
  localparam int P_CH_WIDTH = (P_N_CH > 1) ? $clog2(P_N_CH) : 1;
  localparam logic [P_ADR_WIDTH-1:0] ADR_LAST  = P_ADR_WIDTH'(P_DEPTH - 1);
  localparam logic [P_ADR_WIDTH-1:0] ADR_ONES  = {P_ADR_WIDTH{1'b1}};
  localparam logic [P_ADR_WIDTH-1:0] ADR_ZERO  = {P_ADR_WIDTH{1'b0}};
  localparam logic [2:0]             WAIT_LOAD = 3'(P_HDR_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [2:0]             wait_cnt_r, wait_cnt_s;
  logic [P_ADR_WIDTH-1:0] addr_r, addr_s;
  logic [P_ADR_WIDTH-1:0] stop_r, stop_s;
  logic [P_CH_WIDTH-1:0]  ch_r, ch_s, hdr_ch_s;
  logic                   busy_r, last_r, ovr_r, ovr_s;

  function automatic logic [P_ADR_WIDTH-1:0] ch_addr(
    input logic [P_N_CH*P_ADR_WIDTH-1:0] vec,
    input logic [P_CH_WIDTH-1:0]         ch
  );
    logic [P_ADR_WIDTH-1:0] r;
    r = ADR_ZERO;
    for (int k = 0; k < P_N_CH; k++) begin
      if (ch == P_CH_WIDTH'(k)) begin
        r = vec[k*P_ADR_WIDTH +: P_ADR_WIDTH];
      end
    end
    return r;
  endfunction

  function automatic logic [P_ADR_WIDTH-1:0] adr_next(input logic [P_ADR_WIDTH-1:0] a);
    return (a == ADR_LAST) ? ADR_ZERO : a + P_ADR_WIDTH'(1);
  endfunction

  // Out-of-range channel numbers fall back to channel 0.
  assign hdr_ch_s = ({1'b0, bus.hdr_ch} >= (P_CH_WIDTH+1)'(P_N_CH)) ? {P_CH_WIDTH{1'b0}} : bus.hdr_ch;

  // Next-state and address update; hdr_rdreq beats rddone beats rdreq.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    addr_s     = addr_r;
    stop_s     = stop_r;
    ch_s       = ch_r;
    ovr_s      = ovr_r;
    if (bus.hdr_rdreq) begin
      ch_s       = hdr_ch_s;
      wait_cnt_s = 3'd1;
      ovr_s      = 1'b0;
      state_s    = ST_WAIT;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LOAD) begin
            addr_s  = ch_addr(bus.start_addr, ch_r);
            stop_s  = ch_addr(bus.stop_addr, ch_r);
            state_s = ST_READ;
          end else begin
            wait_cnt_s = wait_cnt_r + 3'd1;
          end
        end
        ST_READ: begin
          if (bus.wvb_rddone) begin
            addr_s  = adr_next(ch_addr(bus.stop_addr, ch_r));
            state_s = ST_IDLE;
          end else if (bus.wvb_rdreq) begin
            addr_s = adr_next(addr_r);
            ovr_s  = ovr_r | last_r;
          end else begin
            addr_s = addr_r;
          end
        end
        ST_IDLE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; rd_last is precomputed so it lines up with the address it qualifies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 3'd0;
      addr_r     <= ADR_ONES;
      stop_r     <= ADR_ZERO;
      ch_r       <= {P_CH_WIDTH{1'b0}};
      busy_r     <= 1'b0;
      last_r     <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      addr_r     <= addr_s;
      stop_r     <= stop_s;
      ch_r       <= ch_s;
      busy_r     <= (state_s != ST_IDLE);
      last_r     <= (state_s == ST_READ) && (addr_s == stop_s);
      ovr_r      <= ovr_s;
    end
  end

  assign bus.wvb_rd_addr = addr_r;
  assign bus.rd_ch       = ch_r;
  assign bus.rd_busy     = busy_r;
  assign bus.rd_last     = last_r;
  assign bus.rd_overrun  = ovr_r;

`ifdef WVB_RD_WORD_CNT_EN
  localparam logic [P_ADR_WIDTH:0] CNT_MAX = {(P_ADR_WIDTH+1){1'b1}};

  logic [P_ADR_WIDTH:0] cnt_r;
  logic                 cnt_clr_s, cnt_inc_s;

  assign cnt_clr_s = !bus.hdr_rdreq && (state_r == ST_WAIT) && (wait_cnt_r == WAIT_LOAD);
  assign cnt_inc_s = !bus.hdr_rdreq && (state_r == ST_READ) && !bus.wvb_rddone && bus.wvb_rdreq;

  // Saturating count of words accepted in the current waveform.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {(P_ADR_WIDTH+1){1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {(P_ADR_WIDTH+1){1'b0}};
    end else if (cnt_inc_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + (P_ADR_WIDTH+1)'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.rd_word_cnt = cnt_r;
`else
  assign bus.rd_word_cnt = {(P_ADR_WIDTH+1){1'b0}};
`endif
endmodule
